// File: rtl/spi_pkg.sv
// Shared types and default sizing for the SPI loopback block.
package spi_pkg;

  localparam int DEF_DATA_W    = 8;
  localparam int DEF_SCLK_HALF = 2;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } master_state_t;

endpackage

// File: rtl/spi_slave.sv
// SPI mode-0 slave: samples mosi on rising-SCLK strobes and publishes a full
// frame when chip select returns high.
module spi_slave
  import spi_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk_rise,
  input  logic              cs_n,
  input  logic              mosi,
  output logic [DATA_W-1:0] rcvd_p_dat,
  output logic              tx_done
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);

  logic [DATA_W-1:0] sh_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic [DATA_W-1:0] rcvd_reg;
  logic              done_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sh_reg   <= '0;
      cnt_reg  <= '0;
      rcvd_reg <= '0;
      done_reg <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (cs_n) begin
        // A partial frame is dropped here: only a full count publishes.
        cnt_reg <= '0;
        if (cnt_reg == CNT_FULL) begin
          rcvd_reg <= sh_reg;
          done_reg <= 1'b1;
        end
      end else if (sclk_rise) begin
        sh_reg  <= {sh_reg[DATA_W-2:0], mosi};
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  assign rcvd_p_dat = rcvd_reg;
  assign tx_done    = done_reg;

endmodule

// File: rtl/spi_top.sv
// SPI loopback: mode-0 master FSM with SCLK divider driving an internal slave.
module spi_top
  import spi_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int SCLK_HALF = DEF_SCLK_HALF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] p_dat,
  input  logic              tx_en,
  output logic [DATA_W-1:0] rcvd_p_dat,
  output logic              tx_done
);

  localparam int DIV_W = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;
  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCLK_HALF - 1);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(DATA_W - 1);

  master_state_t     state_reg, state_next;
  logic              sclk_reg, sclk_next;
  logic              cs_n_reg, cs_n_next;
  logic              mosi_reg, mosi_next;
  logic [DIV_W-1:0]  div_reg, div_next;
  logic [CNT_W-1:0]  bit_reg, bit_next;
  logic [DATA_W-1:0] sh_reg, sh_next;
  logic              half_tick;
  logic              sclk_rise;

  assign half_tick = (state_reg == SHIFT) && (div_reg == DIV_LAST);
  // Rise strobe is asserted on the very edge sclk goes high, so the slave
  // samples mosi that has been stable since the preceding falling edge.
  assign sclk_rise = half_tick && !sclk_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      sclk_reg  <= 1'b0;
      cs_n_reg  <= 1'b1;
      mosi_reg  <= 1'b0;
      div_reg   <= '0;
      bit_reg   <= '0;
      sh_reg    <= '0;
    end else begin
      state_reg <= state_next;
      sclk_reg  <= sclk_next;
      cs_n_reg  <= cs_n_next;
      mosi_reg  <= mosi_next;
      div_reg   <= div_next;
      bit_reg   <= bit_next;
      sh_reg    <= sh_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    sclk_next  = sclk_reg;
    cs_n_next  = cs_n_reg;
    mosi_next  = mosi_reg;
    div_next   = div_reg;
    bit_next   = bit_reg;
    sh_next    = sh_reg;
    case (state_reg)
      IDLE: begin
        sclk_next = 1'b0;
        cs_n_next = 1'b1;
        if (tx_en) begin
          state_next = SHIFT;
          cs_n_next  = 1'b0;
          mosi_next  = p_dat[DATA_W-1];
          sh_next    = p_dat << 1;
          div_next   = '0;
          bit_next   = '0;
        end
      end
      SHIFT: begin
        if (half_tick) begin
          div_next  = '0;
          sclk_next = !sclk_reg;
          if (sclk_reg) begin
            bit_next = bit_reg + 1'b1;
            if (bit_reg == BIT_LAST) begin
              state_next = DONE;
              sclk_next  = 1'b0;
              cs_n_next  = 1'b1;
              mosi_next  = 1'b0;
            end else begin
              mosi_next = sh_reg[DATA_W-1];
              sh_next   = sh_reg << 1;
            end
          end
        end else begin
          div_next = div_reg + 1'b1;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  spi_slave #(
    .DATA_W(DATA_W)
  ) u_slave (
    .clk       (clk),
    .rst       (rst),
    .sclk_rise (sclk_rise),
    .cs_n      (cs_n_reg),
    .mosi      (mosi_reg),
    .rcvd_p_dat(rcvd_p_dat),
    .tx_done   (tx_done)
  );

endmodule

// File: tb/tb_spi_top.sv
// Self-checking bench for spi_top: frame-level timing model plus directed and random traffic.
module tb_spi_top;

  localparam int DW   = 8;
  localparam int SH   = 2;
  localparam int LAT  = 2 * DW * SH + 1;  // start edge to tx_done edge
  localparam int PER  = LAT + 1;          // back-to-back frame period

  logic          clk;
  logic          rst;
  logic [DW-1:0] p_dat;
  logic          tx_en;
  logic [DW-1:0] rcvd_p_dat;
  logic          tx_done;

  spi_top #(.DATA_W(DW), .SCLK_HALF(SH)) dut (
    .clk       (clk),
    .rst       (rst),
    .p_dat     (p_dat),
    .tx_en     (tx_en),
    .rcvd_p_dat(rcvd_p_dat),
    .tx_done   (tx_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Frame-level model: a frame occupies the link from its start edge until
  // LAT edges later, delivering the byte latched at the start edge.
  int unsigned   cyc = 0;
  bit            busy = 0;
  int unsigned   done_at;
  logic [DW-1:0] pend_val;
  logic [DW-1:0] exp_rcvd = '0;
  logic          exp_done = 1'b0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy     = 0;
      exp_rcvd = '0;
      exp_done = 1'b0;
    end else begin
      cyc++;
      exp_done = 1'b0;
      if (busy) begin
        if (cyc == done_at) begin
          exp_rcvd = pend_val;
          exp_done = 1'b1;
          busy     = 0;
        end
      end else if (tx_en) begin
        busy     = 1;
        pend_val = p_dat;
        done_at  = cyc + LAT;
      end
    end
  end

  // Per-cycle compare plus bookkeeping of observed completions.
  int            done_cnt = 0;
  int unsigned   done_cyc_q[$];
  logic [DW-1:0] rx_q[$];
  int            cs_run = 0;
  int            last_gap = 0;

  always @(negedge clk) begin
    chk("tx_done", 32'(tx_done), 32'(exp_done));
    chk("rcvd_p_dat", 32'(rcvd_p_dat), 32'(exp_rcvd));
    if (tx_done) begin
      done_cnt++;
      done_cyc_q.push_back(cyc);
      rx_q.push_back(rcvd_p_dat);
    end
    if (dut.cs_n_reg) cs_run++;
    else begin
      if (cs_run > 0) last_gap = cs_run;
      cs_run = 0;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  int unsigned   e0;
  int            cnt0;
  int            qi;
  logic [DW-1:0] pat[4];

  initial begin
    rst   = 1'b0;
    tx_en = 1'b1;
    p_dat = 8'h55;

    // Reset held with tx_en high: no activity on outputs or internal SPI lines.
    for (int i = 0; i < 5; i++) begin
      step(1);
      chk("rst_rcvd", 32'(rcvd_p_dat), 32'h0);
      chk("rst_done", 32'(tx_done), 32'h0);
      chk("rst_sclk", 32'(dut.sclk_reg), 32'h0);
      chk("rst_cs_n", 32'(dut.cs_n_reg), 32'h1);
    end

    // Single byte, start on the first edge after release.
    rst = 1'b1; p_dat = 8'h69; tx_en = 1'b1;
    e0 = cyc + 1;
    cnt0 = done_cnt;
    step(1);
    tx_en = 1'b0;
    step(40);
    chk("single_pulses", 32'(done_cnt - cnt0), 32'd1);
    chk("single_latency", done_cyc_q[$] - e0, 32'd33);
    chk("single_value", 32'(rcvd_p_dat), 32'h69);

    // Continuous requests.
    qi = done_cyc_q.size();
    tx_en = 1'b1; p_dat = 8'h69;
    step(4 * PER + 2);
    tx_en = 1'b0;
    step(PER + 2);
    chk("cont_frames", 32'(done_cyc_q.size() - qi), 32'd5);
    for (int k = qi + 1; k < done_cyc_q.size(); k++)
      chk("cont_period", done_cyc_q[k] - done_cyc_q[k-1], 32'd34);
    chk("cont_value", 32'(rcvd_p_dat), 32'h69);
    chk("cont_cs_gap", 32'(last_gap >= 1 && last_gap <= 2), 32'd1);

    // p_dat and tx_en changes mid-transfer are ignored.
    cnt0 = done_cnt;
    tx_en = 1'b1; p_dat = 8'hA5;
    step(10);
    p_dat = 8'h3C;
    step(2);
    tx_en = 1'b0;
    step(40);
    chk("latch_value", 32'(rcvd_p_dat), 32'hA5);
    chk("latch_pulses", 32'(done_cnt - cnt0), 32'd1);

    // Abort by reset mid-frame.
    cnt0 = done_cnt;
    tx_en = 1'b1; p_dat = 8'hFF;
    step(1);
    tx_en = 1'b0;
    step(14);
    rst = 1'b0;
    step(2);
    rst = 1'b1;
    step(40);
    chk("abort_pulses", 32'(done_cnt - cnt0), 32'd0);
    chk("abort_value", 32'(rcvd_p_dat), 32'h0);
    tx_en = 1'b1; p_dat = 8'h81;
    step(1);
    tx_en = 1'b0;
    step(40);
    chk("after_abort_value", 32'(rcvd_p_dat), 32'h81);

    // Edge patterns back-to-back.
    pat[0] = 8'h00; pat[1] = 8'hFF; pat[2] = 8'h80; pat[3] = 8'h01;
    qi = rx_q.size();
    tx_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      p_dat = pat[i];
      step(PER);
    end
    tx_en = 1'b0;
    step(5);
    chk("pat_count", 32'(rx_q.size() - qi), 32'd4);
    for (int i = 0; i < 4; i++)
      if (qi + i < rx_q.size()) chk("pat_value", 32'(rx_q[qi+i]), 32'(pat[i]));

    // Random traffic, with occasional resets, checked by the model every cycle.
    for (int i = 0; i < 2000; i++) begin
      p_dat = DW'($urandom);
      tx_en = ($urandom_range(0, 3) != 0);
      rst   = ($urandom_range(0, 399) != 0);
      step(1);
    end
    rst = 1'b1; tx_en = 1'b0;
    step(40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
